// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   hazard_state_t  - controller FSM encoding (RUN / LOAD_STALL / BRANCH_FLUSH)
//   FWD_*           - operand forwarding source select codes
//   REG_PC          - register number that never forwards and never hazards
// ----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'b00,
        LOAD_STALL   = 2'b01,
        BRANCH_FLUSH = 2'b10
    } hazard_state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    localparam logic [3:0] REG_PC = 4'hF;

endpackage

// File: rtl/forward_select.sv
// ----------------------------------------------------------------------------
// forward_select
// Combinational operand-forwarding mux select for one EX-stage operand.
// Ports:
//   src_reg / src_used                  - EX-stage source register and valid
//   ex_mem_rd / ex_mem_reg_write_enable - youngest in-flight producer
//   mem_wb_rd / mem_wb_reg_write_enable - older in-flight producer
//   fwd_sel                             - FWD_RF / FWD_EXMEM / FWD_MEMWB
// ----------------------------------------------------------------------------
module forward_select
    import hazard_pkg::*;
(
    input  logic [3:0] src_reg,
    input  logic       src_used,
    input  logic [3:0] ex_mem_rd,
    input  logic       ex_mem_reg_write_enable,
    input  logic [3:0] mem_wb_rd,
    input  logic       mem_wb_reg_write_enable,
    output logic [1:0] fwd_sel
);

    logic src_ok;
    logic ex_mem_hit;
    logic mem_wb_hit;

    // R15 is the PC, not a general register, so it never forwards.
    assign src_ok     = src_used & (src_reg != REG_PC);
    assign ex_mem_hit = src_ok & ex_mem_reg_write_enable & (ex_mem_rd == src_reg);
    assign mem_wb_hit = src_ok & mem_wb_reg_write_enable & (mem_wb_rd == src_reg);

    // The EX/MEM result is newer, so it wins when both stages write the register.
    always_comb begin
        fwd_sel = FWD_RF;
        if (ex_mem_hit)
            fwd_sel = FWD_EXMEM;
        else if (mem_wb_hit)
            fwd_sel = FWD_MEMWB;
    end

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller: load-use stall insertion, taken-branch flush,
// and EX-stage operand forwarding selection.
// Parameters:
//   STALL_CYCLES - bubbles per load-use hazard (1..7)
//   FLUSH_CYCLES - cycles the IF/ID flush is held after a taken branch (1..3)
// Ports:
//   clk, reset_n (async, active-low)
//   id_rn/id_rm(+_used)            - ID-stage source operands
//   id_ex_*                        - controls latched in ID/EX
//   ex_mem_*/mem_wb_*              - downstream destination/write enables
//   branch_taken_ex                - taken branch resolved in EX
//   pc_load_enable, if_id_load_enable, if_id_flush, id_ex_nop - pipeline control
//   fwd_a_sel, fwd_b_sel           - operand forwarding selects
//   hazard_state                   - FSM state for debug
// Optional build macro HAZARD_STATS_EN adds saturating 16-bit
// stall_count / flush_count outputs.
// ----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic       id_rn_used,
    input  logic       id_rm_used,
    input  logic [3:0] id_ex_rd,
    input  logic       id_ex_reg_write_enable,
    input  logic       id_ex_mem_enable,
    input  logic       id_ex_mem_rw,
    input  logic [3:0] ex_mem_rd,
    input  logic       ex_mem_reg_write_enable,
    input  logic [3:0] mem_wb_rd,
    input  logic       mem_wb_reg_write_enable,
    input  logic       branch_taken_ex,
    output logic       pc_load_enable,
    output logic       if_id_load_enable,
    output logic       if_id_flush,
    output logic       id_ex_nop,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel,
`ifdef HAZARD_STATS_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic [1:0] hazard_state
);

    localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    hazard_state_t state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          load_use;
    logic          rd_ok;
    logic          stall_req;
    logic          flush_req;
    logic          stall_act;
    logic          flush_act;
    logic [7:0]    ex_src;
    logic [1:0]    ex_used;

    // A load in EX whose destination feeds an ID operand needs a bubble.
    assign rd_ok    = id_ex_rd != REG_PC;
    assign load_use = id_ex_mem_enable & ~id_ex_mem_rw & id_ex_reg_write_enable & rd_ok &
                      ((id_rn_used & (id_rn == id_ex_rd)) |
                       (id_rm_used & (id_rm == id_ex_rd)));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first stall/flush cycle is asserted combinationally from RUN; the
    // counter then tracks how many further cycles remain (exit when it hits 1).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_req = 1'b0;
        flush_req = 1'b0;
        unique case (state)
            RUN: begin
                if (branch_taken_ex) begin
                    flush_req = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = BRANCH_FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end
                end else if (load_use) begin
                    stall_req = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_nxt = LOAD_STALL;
                        cnt_nxt   = STALL_RELOAD;
                    end
                end
            end
            LOAD_STALL: begin
                // A branch abandons the stall; this cycle is flush cycle 1.
                if (branch_taken_ex) begin
                    flush_req = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nxt = BRANCH_FLUSH;
                        cnt_nxt   = FLUSH_RELOAD;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                    end
                end else begin
                    stall_req = 1'b1;
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
            end
            BRANCH_FLUSH: begin
                flush_req = 1'b1;
                if (branch_taken_ex) begin
                    // A fresh taken branch restarts the flush sequence.
                    if (FLUSH_CYCLES > 1) begin
                        cnt_nxt = FLUSH_RELOAD;
                    end else begin
                        state_nxt = RUN;
                        cnt_nxt   = 3'd0;
                    end
                end else if (cnt <= 3'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Gating with reset_n keeps the pipeline running while reset is held,
    // even if the ID/EX inputs happen to look like a hazard.
    assign stall_act = stall_req & reset_n;
    assign flush_act = flush_req & reset_n;

    assign pc_load_enable    = ~stall_act;
    assign if_id_load_enable = ~stall_act;
    assign if_id_flush       = flush_act;
    assign id_ex_nop         = stall_act | flush_act;
    assign hazard_state      = state;

    // Source operands travelling alongside ID/EX; a bubble carries no operands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_src  <= 8'd0;
            ex_used <= 2'b00;
        end else if (if_id_load_enable && !id_ex_nop) begin
            ex_src  <= {id_rn, id_rm};
            ex_used <= {id_rn_used, id_rm_used};
        end else begin
            ex_src  <= 8'd0;
            ex_used <= 2'b00;
        end
    end

    forward_select u_fwd_a (
        .src_reg                 (ex_src[7:4]),
        .src_used                (ex_used[1]),
        .ex_mem_rd               (ex_mem_rd),
        .ex_mem_reg_write_enable (ex_mem_reg_write_enable),
        .mem_wb_rd               (mem_wb_rd),
        .mem_wb_reg_write_enable (mem_wb_reg_write_enable),
        .fwd_sel                 (fwd_a_sel)
    );

    forward_select u_fwd_b (
        .src_reg                 (ex_src[3:0]),
        .src_used                (ex_used[0]),
        .ex_mem_rd               (ex_mem_rd),
        .ex_mem_reg_write_enable (ex_mem_reg_write_enable),
        .mem_wb_rd               (mem_wb_rd),
        .mem_wb_reg_write_enable (mem_wb_reg_write_enable),
        .fwd_sel                 (fwd_b_sel)
    );

`ifdef HAZARD_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            if (stall_act)
                stall_count <= sat_inc(stall_count);
            if (flush_act)
                flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
Pipeline hazard controller that consumes the control fields latched in the ID/EX control register and drives that register's inputs in turn, along with the PC and IF/ID load enables.
- Detects load-use hazards and inserts bubbles (zeroed ID/EX controls).
- Flushes younger instructions on a taken branch resolved in EX.
- Selects operand forwarding sources for the EX stage.
- Sits between the decode-stage control unit and the ID/EX control register.

Parameters:
STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 models multi-cycle data memory)
FLUSH_CYCLES, 1, cycles IF/ID flush held after a taken branch (1..3)

Ports:
clk  in  1  pipeline clock
reset_n  in  1  asynchronous active-low reset
id_rn  in  4  ID-stage first source register
id_rm  in  4  ID-stage second source register
id_rn_used  in  1  id_rn is a real operand
id_rm_used  in  1  id_rm is a real operand
id_ex_rd  in  4  destination held in ID/EX
id_ex_reg_write_enable  in  1  ID/EX register write enable
id_ex_mem_enable  in  1  ID/EX memory enable
id_ex_mem_rw  in  1  ID/EX memory direction, 0=read (load), 1=write
ex_mem_rd  in  4  EX/MEM destination
ex_mem_reg_write_enable  in  1  EX/MEM register write enable
mem_wb_rd  in  4  MEM/WB destination
mem_wb_reg_write_enable  in  1  MEM/WB register write enable
branch_taken_ex  in  1  taken branch resolved in EX this cycle
pc_load_enable  out  1  PC may advance
if_id_load_enable  out  1  IF/ID may load
if_id_flush  out  1  IF/ID loads a NOP
id_ex_nop  out  1  ID/EX control inputs forced to 0
fwd_a_sel  out  2  operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB
fwd_b_sel  out  2  operand B source, same encoding
hazard_state  out  2  FSM state, for debug

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous, active-low.
- While reset_n is low:
  - FSM is in RUN and the counter is 0.
  - Stall and flush outputs are inactive: pc_load_enable=1, if_id_load_enable=1, if_id_flush=0, id_ex_nop=0.
  - fwd_*_sel are still combinational from their inputs.
- load_use = id_ex_mem_enable & ~id_ex_mem_rw & id_ex_reg_write_enable & ((id_rn_used & id_rn==id_ex_rd) | (id_rm_used & id_rm==id_ex_rd)).
- FSM states: RUN=00, LOAD_STALL=01, BRANCH_FLUSH=10. Counter is 3 bits.
- RUN:
  - branch_taken_ex: assert if_id_flush=1 and id_ex_nop=1 in the same cycle (combinational). If FLUSH_CYCLES>1, go to BRANCH_FLUSH with count=FLUSH_CYCLES-1.
  - else load_use: assert pc_load_enable=0, if_id_load_enable=0, id_ex_nop=1 in the same cycle. If STALL_CYCLES>1, go to LOAD_STALL with count=STALL_CYCLES-1.
- LOAD_STALL:
  - Hold the stall outputs and decrement count each cycle.
  - Return to RUN on the cycle count reaches 1, i.e. exactly STALL_CYCLES stall cycles in total.
- BRANCH_FLUSH: same pattern, holding if_id_flush=1 and id_ex_nop=1.
- Priority: branch_taken_ex beats load_use in every state. A branch during LOAD_STALL aborts the stall and enters the flush sequence, with the current cycle counted as flush cycle 1.
- Forwarding is purely combinational, with zero latency.
  - fwd_a_sel=01 if ex_mem_reg_write_enable & ex_mem_rd==id_ex source A.
  - Else 10 if the MEM/WB match holds.
  - Else 00.
  - EX/MEM has priority over MEM/WB. fwd_b is identical.
  - EX source registers come from an internal 8-bit register that captures {id_rn,id_rm} when if_id_load_enable=1 and id_ex_nop=0, and captures 0 otherwise.
  - That capture register's used bits are cleared on a bubble, so no forwarding is selected for a bubble.
- Register R15 (4'hF) is never a forwarding or hazard match.
- An asynchronous reset mid-stall or mid-flush returns immediately to RUN with all stall/flush outputs inactive.

Optional Feature:
HAZARD_STATS_EN:
- Defined: adds outputs stall_count[15:0] and flush_count[15:0]. Each increments once per stall/flush cycle and saturates at 16'hFFFF. Both reset to 0 on reset_n low.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package hazard_pkg:
  - state enum (RUN, LOAD_STALL, BRANCH_FLUSH)
  - forwarding select constants FWD_RF, FWD_EXMEM, FWD_MEMWB
  - REG_PC=4'hF
- One natural sub-module, forward_select: purely combinational, instantiated twice for operands A and B.

Test Plan:
- Load R3 in ID/EX (mem_enable=1, mem_rw=0, rd=3), ID reads id_rn=3 used, STALL_CYCLES=1 -> exactly one cycle of pc_load_enable=0, if_id_load_enable=0, id_ex_nop=1, then RUN.
- Same hazard with STALL_CYCLES=3 -> stall held 3 consecutive cycles; hazard_state 01 for cycles 2-3; returns to 00.
- branch_taken_ex=1 coincident with a load-use hazard -> if_id_flush=1, id_ex_nop=1, pc_load_enable=1 (branch wins).
- EX/MEM rd=5 write=1 and MEM/WB rd=5 write=1, EX operand A=R5 -> fwd_a_sel=01; drop EX/MEM write -> 10; rd=15 -> 00.
- reset_n pulsed low in the second cycle of a 3-cycle stall -> outputs return to the inactive values immediately (asynchronously), FSM in RUN.
- HAZARD_STATS_EN defined: 4 stalls of STALL_CYCLES=2 plus 1 flush -> stall_count=8, flush_count=1.
